// File: rtl/dtree_result_queue.sv
// Result queue for the decision-tree classifier.
// Each classifier result is tagged with a free-running sample timestamp and
// stored in a small FIFO that the readout drains over valid/ready.
// When the FIFO is full and nothing is popped, the result is dropped. A
// saturating drop counter and a sticky overflow flag record each loss.
module dtree_result_queue #(
    parameter int FEATURES   = 3,
    parameter int DEPTH      = 8,
    parameter int TS_WIDTH   = 16,
    parameter int DROP_WIDTH = 8,
    localparam int LW = $clog2(FEATURES),
    localparam int AW = $clog2(DEPTH),
    localparam int DW = TS_WIDTH + 2 * LW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_tick,
    input  logic [LW-1:0]         in_level,
    input  logic [LW-1:0]         in_path,
    input  logic                  in_valid,
    output logic [DW-1:0]         out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [AW:0]           count,
    output logic [DROP_WIDTH-1:0] drop_count,
    output logic                  overflow,
    input  logic                  clear_overflow
);

    localparam logic [AW:0]           FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [DROP_WIDTH-1:0] DROP_MAX = '1;

    logic [DW-1:0]         mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic [TS_WIDTH-1:0]   ts_q, ts_d;
    logic [DW-1:0]         out_data_q, out_data_d;
    logic [DROP_WIDTH-1:0] drop_count_q, drop_count_d;
    logic                  overflow_q, overflow_d;

    logic          pop;
    logic          full;
    logic          push_ok;
    logic          drop;
    logic [DW-1:0] entry;

    // Handshake decode. A full FIFO still accepts a push when a pop
    // frees a slot in the same cycle.
    always_comb begin
        pop     = (count_q != '0) && out_ready;
        full    = (count_q == FULL_CNT);
        push_ok = in_valid && (!full || pop);
        drop    = in_valid && full && !pop;
        entry   = {ts_q, in_level, in_path};
    end

    // Pointers, occupancy and timestamp next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        ts_d     = ts_q + TS_WIDTH'(sample_tick);
        count_d  = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Next head-of-queue register value. If the slot being written this
    // cycle becomes the head, the new entry bypasses the array. When the
    // FIFO goes empty, the last value is held.
    always_comb begin
        out_data_d = out_data_q;
        if (count_d != '0) begin
            if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
                out_data_d = entry;
            end else begin
                out_data_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Drop accounting. A clear and a drop in the same cycle leave one
    // recorded drop, so the loss is never hidden.
    always_comb begin
        drop_count_d = drop_count_q;
        overflow_d   = overflow_q;
        if (clear_overflow) begin
            drop_count_d = '0;
            overflow_d   = 1'b0;
        end
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_overflow) begin
                drop_count_d = DROP_WIDTH'(1);
            end else if (drop_count_q != DROP_MAX) begin
                drop_count_d = drop_count_q + 1'b1;
            end
        end
    end

    // Storage array. It has no reset, because the pointers and count
    // define which slots are live.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= entry;
        end
    end

    // Control and status state, with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ts_q         <= '0;
            out_data_q   <= '0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ts_q         <= ts_d;
            out_data_q   <= out_data_d;
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = (count_q != '0);
    assign count      = count_q;
    assign drop_count = drop_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_dtree_result_queue.sv
// Directed bench for dtree_result_queue.
// The stimulus pushes expected entries into a scoreboard queue.
// A negedge monitor pops from the queue and compares on every accepted output.
module tb_dtree_result_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_tick = 1'b0;
    logic [1:0]  in_level = '0;
    logic [1:0]  in_path = '0;
    logic        in_valid = 1'b0;
    logic [19:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  count;
    logic [7:0]  drop_count;
    logic        overflow;
    logic        clear_overflow = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    logic [19:0] sb[$];
    int          m_count = 0;
    logic [15:0] m_ts = '0;

    dtree_result_queue dut (
        .clk            (clk),
        .reset          (reset),
        .sample_tick    (sample_tick),
        .in_level       (in_level),
        .in_path        (in_path),
        .in_valid       (in_valid),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .count          (count),
        .drop_count     (drop_count),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    // Monitor: compare every accepted output against the scoreboard.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got %h, required no output", out_data);
            end else begin
                logic [19:0] exp_d;
                exp_d = sb.pop_front();
                if (out_data !== exp_d) begin
                    n_fail++;
                    $display("FAIL pop_data: got %h required %h", out_data, exp_d);
                end else begin
                    $display("pop ts=%0d level=%0d path=%0d", out_data[19:4], out_data[3:2], out_data[1:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp_v);
        end else begin
            $display("check %s = %0h", name, act);
        end
    endtask

    // Drive one cycle of inputs, record expected entries, and return to idle at posedge+1.
    task automatic step(input logic tick, input logic valid, input logic [1:0] lvl,
                        input logic [1:0] pth, input logic rdy, input logic clr);
        logic pop;
        sample_tick    = tick;
        in_valid       = valid;
        in_level       = lvl;
        in_path        = pth;
        out_ready      = rdy;
        clear_overflow = clr;
        pop = (m_count > 0) && rdy;
        if (valid && (m_count < 8 || pop)) begin
            sb.push_back({m_ts, lvl, pth});
            m_count++;
        end
        if (pop) m_count--;
        if (tick) m_ts++;
        @(posedge clk);
        #1;
        sample_tick    = 1'b0;
        in_valid       = 1'b0;
        out_ready      = 1'b0;
        clear_overflow = 1'b0;
    endtask

    task automatic drain(input string name);
        int i;
        out_ready = 1'b1;
        i = 0;
        while (out_valid && i < 20) begin
            @(posedge clk);
            #1;
            i++;
        end
        out_ready = 1'b0;
        m_count = 0;
        check({name, "_empty"}, {31'd0, out_valid}, 32'd0);
        check({name, "_sb_left"}, sb.size(), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_valid", {31'd0, out_valid}, 0);
        check("rst_count", {28'd0, count}, 0);
        check("rst_drop", {24'd0, drop_count}, 0);
        check("rst_ovf", {31'd0, overflow}, 0);
        check("rst_data", {12'd0, out_data}, 0);

        // Latency: 5 ticks, then one push.
        repeat (5) step(1, 0, 0, 0, 0, 0);
        step(0, 1, 2'd2, 2'd1, 0, 0);
        check("first_valid", {31'd0, out_valid}, 1);
        check("first_data", {12'd0, out_data}, 32'h00059);
        check("first_count", {28'd0, count}, 1);
        drain("t1");

        // Fill, overflow by one, then replace an entry while full.
        for (int i = 0; i < 8; i++) step(1, 1, 2'(i / 4), 2'(i % 4), 0, 0);
        check("fill_count", {28'd0, count}, 8);
        step(0, 1, 2'd3, 2'd3, 0, 0);
        check("drop1_count", {24'd0, drop_count}, 1);
        check("drop1_ovf", {31'd0, overflow}, 1);
        check("drop1_fifo", {28'd0, count}, 8);
        step(0, 1, 2'd3, 2'd2, 1, 0);
        check("swap_count", {28'd0, count}, 8);
        check("swap_drop", {24'd0, drop_count}, 1);
        drain("t2");

        // Saturating drop counter and clear behaviour.
        step(0, 0, 0, 0, 0, 1);
        check("clr_drop", {24'd0, drop_count}, 0);
        check("clr_ovf", {31'd0, overflow}, 0);
        repeat (8) step(0, 1, 2'd1, 2'd1, 0, 0);
        repeat (300) step(0, 1, 2'd2, 2'd2, 0, 0);
        check("sat_drop", {24'd0, drop_count}, 32'hFF);
        check("sat_ovf", {31'd0, overflow}, 1);
        step(0, 0, 0, 0, 0, 1);
        check("clr2_drop", {24'd0, drop_count}, 0);
        check("clr2_ovf", {31'd0, overflow}, 0);
        step(0, 1, 2'd0, 2'd0, 0, 1);
        check("clrdrop_drop", {24'd0, drop_count}, 1);
        check("clrdrop_ovf", {31'd0, overflow}, 1);
        check("clrdrop_count", {28'd0, count}, 8);
        drain("t5");

        // Timestamp wrap.
        while (m_ts != 16'hFFFF) step(1, 0, 0, 0, 0, 0);
        step(1, 1, 2'd1, 2'd0, 0, 0);
        check("wrap_ts_hi", {16'd0, out_data[19:4]}, 32'hFFFF);
        step(0, 1, 2'd0, 2'd1, 0, 0);
        check("wrap_count", {28'd0, count}, 2);
        drain("t4");

        // Asynchronous reset with four entries queued. The overflow flag is still set from the previous test.
        repeat (4) step(0, 1, 2'd2, 2'd3, 0, 0);
        check("pre_rst_count", {28'd0, count}, 4);
        #2 reset = 1'b1;
        #1;
        check("arst_valid", {31'd0, out_valid}, 0);
        check("arst_count", {28'd0, count}, 0);
        check("arst_ovf", {31'd0, overflow}, 0);
        sb.delete();
        m_count = 0;
        m_ts = '0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_valid", {31'd0, out_valid}, 0);
        check("post_rst_count", {28'd0, count}, 0);
        step(0, 1, 2'd3, 2'd3, 0, 0);
        check("post_rst_data", {12'd0, out_data}, 32'h0000F);
        drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
